// File: rtl/led_s2p_rx.sv
// Serial-to-parallel receiver for the 16-LED link: oversamples LED_CLK/LED_DO and emits each completed frame.
// Define LED_RX_TIMEOUT_EN to abort partial frames after TIMEOUT clk cycles of LED_CLK idling high.
module led_s2p_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LED_CLK,
  input  logic             LED_DO,
  input  logic             LED_CLR,
  input  logic             LED_EN,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] clkSync_q, doSync_q, clrSync_q, enSync_q;
  logic                   clkPrev_q;
  logic                   clkS, doS, clrS, enS;
  logic                   fall_q, en_q, bit_q, clrLow_q;
  state_t                 state_q;
  logic [WIDTH-1:0]       sh_q, data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   valid_q, err_q;

  assign clkS = clkSync_q[SYNC_STAGES-1];
  assign doS  = doSync_q[SYNC_STAGES-1];
  assign clrS = clrSync_q[SYNC_STAGES-1];
  assign enS  = enSync_q[SYNC_STAGES-1];

  // Chains reset to the idle-high level so leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync_q <= '1;
      doSync_q  <= '1;
      clrSync_q <= '1;
      enSync_q  <= '1;
      clkPrev_q <= 1'b1;
    end else begin
      clkSync_q <= {clkSync_q[SYNC_STAGES-2:0], LED_CLK};
      doSync_q  <= {doSync_q[SYNC_STAGES-2:0], LED_DO};
      clrSync_q <= {clrSync_q[SYNC_STAGES-2:0], LED_CLR};
      enSync_q  <= {enSync_q[SYNC_STAGES-2:0], LED_EN};
      clkPrev_q <= clkS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fall_q   <= 1'b0;
      en_q     <= 1'b0;
      bit_q    <= 1'b0;
      clrLow_q <= 1'b0;
    end else begin
      fall_q   <= clkPrev_q & ~clkS;
      en_q     <= enS;
      bit_q    <= ~doS;
      clrLow_q <= ~clrS;
    end
  end

`ifdef LED_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT > 0);
`endif

  // Clear beats a simultaneous fall; the WIDTH-th accepted bit publishes the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef LED_RX_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (clrLow_q) begin
        sh_q    <= '0;
        cnt_q   <= '0;
        state_q <= IDLE;
        err_q   <= (cnt_q != '0);
`ifdef LED_RX_TIMEOUT_EN
        idle_q  <= '0;
`endif
      end else if (fall_q && en_q) begin
`ifdef LED_RX_TIMEOUT_EN
        idle_q <= '0;
`endif
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          data_q  <= {sh_q[WIDTH-2:0], bit_q};
          valid_q <= 1'b1;
          sh_q    <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end else begin
          sh_q    <= {sh_q[WIDTH-2:0], bit_q};
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= SHIFT;
        end
      end
`ifdef LED_RX_TIMEOUT_EN
      else if (state_q == SHIFT) begin
        if (fall_q) begin
          idle_q <= '0;
        end else if (clkS) begin
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            err_q   <= 1'b1;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
      end
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q == SHIFT);
  assign frame_err = err_q;

endmodule

// File: tb/tb_led_s2p_rx.sv
// Self-checking bench for led_s2p_rx: randomized serial frames checked against a bit-queue frame model.
// Builds with or without LED_RX_TIMEOUT_EN; the timeout scenario adapts its expectations.
module tb_led_s2p_rx;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          LED_CLK, LED_DO, LED_CLR, LED_EN;
  logic [W-1:0]  data;
  logic          valid, busy, frame_err;

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  expQ[$];
  logic [W-1:0]  gotQ[$];
  int            expErr = 0;
  int            gotErr = 0;
  bit            modelBits[$];
  logic [W-1:0]  expData = '0;

  led_s2p_rx dut (
    .clk(clk), .rst(rst), .LED_CLK(LED_CLK), .LED_DO(LED_DO), .LED_CLR(LED_CLR),
    .LED_EN(LED_EN), .data(data), .valid(valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Collects every valid frame and every error pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) gotQ.push_back(data);
      if (frame_err) gotErr++;
    end
  end

  // Frame model: accepted bits accumulate, MSB first; the WIDTH-th completes a frame.
  task automatic modelPush(input bit b);
    logic [W-1:0] word;
    modelBits.push_back(b);
    if (modelBits.size() == W) begin
      word = '0;
      foreach (modelBits[i]) word = {word[W-2:0], modelBits[i]};
      expQ.push_back(word);
      expData = word;
      modelBits.delete();
    end
  endtask

  task automatic sendBit(input bit b, input bit en, input int hi, input int lo);
    LED_DO = ~b;
    LED_EN = en;
    repeat (hi) @(negedge clk);
    LED_CLK = 1'b0;
    if (en) modelPush(b);
    repeat (lo) @(negedge clk);
    LED_CLK = 1'b1;
  endtask

  task automatic sendWord(input logic [W-1:0] w, input bit randPhase);
    for (int i = W - 1; i >= 0; i--) begin
      if (randPhase) sendBit(w[i], 1'b1, $urandom_range(2, 5), $urandom_range(2, 5));
      else sendBit(w[i], 1'b1, 2, 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; LED_CLK = 1'b1; LED_DO = 1'b1; LED_CLR = 1'b1; LED_EN = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0000", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] w = 16'hA5C3;
    int lat = -1;
    for (int i = W - 1; i >= 1; i--) sendBit(w[i], 1'b1, 2, 2);
    LED_DO = ~w[0];
    repeat (2) @(negedge clk);
    LED_CLK = 1'b0;
    modelPush(w[0]);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid && lat < 0) lat = k;
    end
    LED_CLK = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++;
    if (gotQ.size() !== expQ.size()) begin
      failures++; $display("FAIL basic_count got=%0d exp=%0d", gotQ.size(), expQ.size());
    end else foreach (expQ[i]) begin
      checks++;
      if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL basic_frame got=%h exp=%h", gotQ[i], expQ[i]); end
    end
    checks++; if (data !== 16'hA5C3) begin failures++; $display("FAIL basic_data got=%h exp=a5c3", data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
    gotQ.delete(); expQ.delete();
  endtask

  task automatic test_back_to_back();
    sendWord(16'h0001, 1'b0);
    sendWord(16'hFFFF, 1'b0);
    for (int n = 0; n < 6; n++) sendWord(W'($urandom), 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (gotQ.size() !== expQ.size()) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", gotQ.size(), expQ.size());
    end else foreach (expQ[i]) begin
      checks++;
      if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL b2b_frame%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
    end
    checks++; if (data !== expData) begin failures++; $display("FAIL b2b_data got=%h exp=%h", data, expData); end
    checks++; if (gotErr !== expErr) begin failures++; $display("FAIL b2b_err got=%0d exp=%0d", gotErr, expErr); end
    gotQ.delete(); expQ.delete();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 7; i++) sendBit(bit'($urandom_range(0, 1)), 1'b1, 2, 2);
    LED_CLR = 1'b0;
    if (modelBits.size() != 0) expErr++;
    modelBits.delete();
    repeat (4) @(negedge clk);
    LED_CLR = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (gotErr !== expErr) begin failures++; $display("FAIL clr_err got=%0d exp=%0d", gotErr, expErr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy); end
    checks++; if (data !== expData) begin failures++; $display("FAIL clr_data_held got=%h exp=%h", data, expData); end
    checks++; if (gotQ.size() !== 0) begin failures++; $display("FAIL clr_no_valid got=%0d exp=0", gotQ.size()); end
    sendWord(16'h1234, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if (data !== 16'h1234) begin failures++; $display("FAIL clr_next_data got=%h exp=1234", data); end
    checks++;
    if (gotQ.size() !== expQ.size()) begin failures++; $display("FAIL clr_count got=%0d exp=%0d", gotQ.size(), expQ.size()); end
    gotQ.delete(); expQ.delete();
  endtask

  task automatic test_enable();
    logic [W-1:0] w = W'($urandom);
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 9) for (int j = 0; j < 3; j++) sendBit(bit'($urandom_range(0, 1)), 1'b0, 2, 3);
      sendBit(w[i], 1'b1, 2, 2);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (gotQ.size() !== 1) begin
      failures++; $display("FAIL en_count got=%0d exp=1", gotQ.size());
    end else begin
      checks++;
      if (gotQ[0] !== expQ[0]) begin failures++; $display("FAIL en_frame got=%h exp=%h", gotQ[0], expQ[0]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_busy got=%b exp=0", busy); end
    gotQ.delete(); expQ.delete();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) sendBit(bit'($urandom_range(0, 1)), 1'b1, 2, 2);
    repeat (70) @(negedge clk);
`ifdef LED_RX_TIMEOUT_EN
    expErr++;
    modelBits.delete();
    checks++; if (gotErr !== expErr) begin failures++; $display("FAIL to_err got=%0d exp=%0d", gotErr, expErr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", busy); end
    sendWord(16'hBEEF, 1'b1);
`else
    checks++; if (gotErr !== expErr) begin failures++; $display("FAIL to_err got=%0d exp=%0d", gotErr, expErr); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_busy_held got=%b exp=1", busy); end
    for (int i = 0; i < 11; i++) sendBit(bit'($urandom_range(0, 1)), 1'b1, 2, 2);
`endif
    repeat (8) @(negedge clk);
    checks++;
    if (gotQ.size() !== 1) begin
      failures++; $display("FAIL to_count got=%0d exp=1", gotQ.size());
    end else begin
      checks++;
      if (gotQ[0] !== expQ[0]) begin failures++; $display("FAIL to_frame got=%h exp=%h", gotQ[0], expQ[0]); end
    end
    gotQ.delete(); expQ.delete();
  endtask

  task automatic test_reset_mid();
    int errBefore = gotErr;
    for (int i = 0; i < 9; i++) sendBit(bit'($urandom_range(0, 1)), 1'b1, 2, 2);
    rst = 1'b1;
    modelBits.delete();
    expData = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (data !== expData) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", data, expData); end
    checks++; if (gotErr !== errBefore) begin failures++; $display("FAIL rstmid_err got=%0d exp=%0d", gotErr, errBefore); end
    checks++; if (gotQ.size() !== 0) begin failures++; $display("FAIL rstmid_no_valid got=%0d exp=0", gotQ.size()); end
    sendWord(W'($urandom), 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (gotQ.size() !== 1) begin
      failures++; $display("FAIL rstmid_count got=%0d exp=1", gotQ.size());
    end else begin
      checks++;
      if (gotQ[0] !== expQ[0]) begin failures++; $display("FAIL rstmid_frame got=%h exp=%h", gotQ[0], expQ[0]); end
    end
    checks++; if (data !== expData) begin failures++; $display("FAIL rstmid_final_data got=%h exp=%h", data, expData); end
    gotQ.delete(); expQ.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clear();
    test_enable();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
